// File: rtl/bm_dag_pipe_param_if.sv
// Handshake/data bundle for bm_dag_pipe_param: upstream offer, downstream result and counter.
// Carries out_par only when DAG_PARITY_EN is defined.
interface bm_dag_pipe_param_if #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CNT_BITS = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a_in;
    logic [WIDTH-1:0]    b_in;
    logic [1:0]          op_sel;
    logic                c_in;
    logic                d_in;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out0;
    logic                out1;
    logic [CNT_BITS-1:0] count;
`ifdef DAG_PARITY_EN
    logic                out_par;
`endif

    modport master (
        output in_valid, a_in, b_in, op_sel, c_in, d_in, out_ready,
`ifdef DAG_PARITY_EN
        input  out_par,
`endif
        input  in_ready, out_valid, out0, out1, count
    );

    modport slave (
        input  in_valid, a_in, b_in, op_sel, c_in, d_in, out_ready,
`ifdef DAG_PARITY_EN
        output out_par,
`endif
        output in_ready, out_valid, out0, out1, count
    );
endinterface

// File: rtl/bm_dag_pipe_param.sv
// Back-pressured DEPTH-stage XOR-reconvergent DAG pipeline with a c&d side path and result counter.
// Optional registered parity output enabled by the DAG_PARITY_EN macro.
module bm_dag_pipe_param #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned CNT_BITS = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    bm_dag_pipe_param_if.slave bus
);
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] p_q;
    logic [DEPTH-1:0][WIDTH-1:0] x_q;
    logic [DEPTH-1:0][WIDTH-1:0] ra_q;
    logic [DEPTH-1:0]            s_q;

    logic                        out_valid_q;
    logic [WIDTH-1:0]            out0_q;
    logic                        out1_q;
    logic [CNT_BITS-1:0]         count_q;
`ifdef DAG_PARITY_EN
    logic                        out_par_q;
`endif

    logic                        stall;
    logic                        accept;
    logic                        deliver;
    logic [WIDTH-1:0]            op_res;
    logic [WIDTH-1:0]            dag_res;

    always_comb begin
        op_res = '0;
        case (bus.op_sel)
            2'b00:   op_res = bus.a_in & bus.b_in;
            2'b01:   op_res = bus.a_in | bus.b_in;
            2'b10:   op_res = bus.a_in ^ bus.b_in;
            default: op_res = ~(bus.a_in ^ bus.b_in);
        endcase
    end

    // A single global stall freezes every stage, so in_ready depends only on the output register.
    assign stall   = out_valid_q & ~bus.out_ready;
    assign accept  = bus.in_valid & ~stall;
    assign deliver = out_valid_q & bus.out_ready;
    assign dag_res = p_q[DEPTH-1] & x_q[DEPTH-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q     <= '0;
            p_q         <= '0;
            x_q         <= '0;
            ra_q        <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= 1'b0;
            count_q     <= '0;
`ifdef DAG_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            if (!stall) begin
                valid_q[0] <= accept;
                p_q[0]     <= op_res;
                x_q[0]     <= op_res;
                ra_q[0]    <= bus.a_in;
                s_q[0]     <= bus.c_in & bus.d_in;
                // Each stage re-XORs the carried operand A, so x alternates between OP and A^OP.
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    valid_q[k] <= valid_q[k-1];
                    p_q[k]     <= p_q[k-1];
                    x_q[k]     <= ra_q[k-1] ^ x_q[k-1];
                    ra_q[k]    <= ra_q[k-1];
                    s_q[k]     <= s_q[k-1];
                end
                out_valid_q <= valid_q[DEPTH-1];
                out0_q      <= dag_res;
                out1_q      <= s_q[DEPTH-1];
`ifdef DAG_PARITY_EN
                out_par_q   <= ^dag_res;
`endif
            end
            if (deliver) begin
                count_q <= count_q + CNT_BITS'(1);
            end
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;
    assign bus.count     = count_q;
`ifdef DAG_PARITY_EN
    assign bus.out_par   = out_par_q;
`endif
endmodule

// File: doc/bm_dag_pipe_param.md
Name: bm_dag_pipe_param

Overview:
- Parametrised, back-pressured successor to the fixed 2-bit AND/XOR register DAG micro-benchmark.
- Computes a selectable bitwise op of a_in/b_in. Feeds it through a DEPTH-stage XOR-reconvergent chain. ANDs the aligned short and long branches into a registered output.
- Carries a 1-bit c_in&d_in side path and counts delivered results.
- Used as a synthesis/elaboration regression block: parametrised width and depth, valid/ready flow control, synchronous reset.

Parameters:
- WIDTH, 2, bit width of a_in, b_in and out0 (>=1)
- DEPTH, 3, number of internal chain stages before the output register (>=1)
- CNT_BITS, 8, width of the delivered-result counter (>=1)

Ports:
- clock  input  1  single clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream offers a_in/b_in/op_sel/c_in/d_in
- in_ready  output  1  block can accept this cycle
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- op_sel  input  2  00 AND, 01 OR, 10 XOR, 11 XNOR (applied to a_in, b_in)
- c_in  input  1  side-path operand
- d_in  input  1  side-path operand
- out_valid  output  1  out0/out1 hold a result
- out_ready  input  1  downstream accepts the result
- out0  output  WIDTH  DAG result
- out1  output  1  registered c_in & d_in of the same transaction
- count  output  CNT_BITS  number of results delivered

Behaviour:
- Reset: one clock domain only. Reset is synchronous and active-low: reset_n is sampled low at a rising edge of clock.
  - On reset, all stage valid bits, out_valid, out0, out1 and count go to 0. Stage data registers also go to 0.
  - Reset dominates any simultaneous transfer. An in_valid or out_ready handshake at a reset edge is discarded and does not increment count.
  - Reset mid-flight drops all in-flight transactions.
- Stall: stall = out_valid & !out_ready; in_ready = !stall (combinational).
  - When stall=1, every stage and the output register hold their contents. out0/out1 stay stable until accepted.
  - When stall=0, the whole pipeline advances one stage per edge. Bubbles advance as invalid entries.
- Accept: accept = in_valid & in_ready at a rising edge. Stage 1 captures:
  - valid=accept
  - p=OP(a_in,b_in)
  - x=p
  - ra=a_in
  - s=c_in&d_in
  - Non-accepted cycles load valid=0; data is don't-care.
- Stages k=2..DEPTH:
  - p_k=p_(k-1), ra_k=ra_(k-1), s_k=s_(k-1)
  - x_k = ra_(k-1) ^ x_(k-1)
  - valid_k = valid_(k-1)
- Output register:
  - out0 <= p_DEPTH & x_DEPTH
  - out1 <= s_DEPTH
  - out_valid <= valid_DEPTH
- Closed form (for checking):
  - DEPTH odd: out0 = OP(a,b)
  - DEPTH even: out0 = OP(a,b) & (a ^ OP(a,b))
- Latency:
  - With no stall, a transaction accepted at edge t appears with out_valid=1 after edge t+DEPTH.
  - Throughput 1 per cycle. Order is preserved.
- Counter: count increments by 1 on each edge with out_valid & out_ready and no reset. It wraps from 2^CNT_BITS-1 to 0.
- Simultaneous events:
  - Output accepted and a new input accepted on the same edge is legal; the pipeline advances normally.
  - out_ready=1 while out_valid=0 has no effect.
- Arithmetic: bitwise only, all WIDTH bits. There is no carry or overflow.

Optional Feature:
- Macro: DAG_PARITY_EN
- Defined:
  - Adds output port out_par (1 bit), registered alongside out0: out_par <= ^(p_DEPTH & x_DEPTH).
  - out_par resets to 0 and holds during stall.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=4, DEPTH=3, reset then one transaction: op_sel=10, a_in=4'b1100, b_in=4'b1010, c_in=1, d_in=1, out_ready=1 -> out_valid=1 exactly 3 edges after accept; out0=4'b0110, out1=1, count=1 on the following edge.
2. WIDTH=4, DEPTH=2, op_sel=01, a_in=4'b1100, b_in=4'b1010 -> out0=4'b0010 after 2 edges. Same inputs with op_sel=00 -> out0=4'b0000.
3. Back-to-back stream of 5 transactions with out_ready held 0 once the first result appears -> in_ready=0 while out_valid=1; out0 stable for 4 held cycles; after out_ready=1 all 5 emerge in order, one per cycle; count=5.
4. reset_n=0 for one edge while 2 transactions are in flight and out_valid=1 -> next cycle out_valid=0, out0=0, out1=0, count=0, in_ready=1; no stale result ever appears.
5. CNT_BITS=2, deliver 5 results with out_ready=1 -> count sequence 1,2,3,0,1.
6. DAG_PARITY_EN defined, DEPTH=3, op_sel=11, a_in=4'b1100, b_in=4'b1010 -> out0=4'b1001, out_par=0. Then a_in=4'b1110, b_in=4'b0000, op_sel=01 -> out0=4'b1110, out_par=1.
